// File: rtl/arb_pkg.sv
// Shared definitions for the three-requester memory port arbiter.
// Contents: requester count, FSM state type, mux select encodings and a
// one-hot grant to mux-select helper.
package arb_pkg;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic [SEL_W-1:0] SEL_REQ0 = 2'b00;
    localparam logic [SEL_W-1:0] SEL_REQ1 = 2'b01;
    localparam logic [SEL_W-1:0] SEL_REQ2 = 2'b10;

    // Encode a one-hot grant as the datapath mux select; all-zero maps to requester 0.
    function automatic logic [SEL_W-1:0] onehot_to_sel(input logic [NUM_REQ-1:0] oh);
        logic [SEL_W-1:0] sel;
        sel = SEL_REQ0;
        if (oh[2]) begin
            sel = SEL_REQ2;
        end else if (oh[1]) begin
            sel = SEL_REQ1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the requesters/memory port and the arbiter.
// Signals: req, last, port_ready (toward arbiter); grant, mux_sel,
// port_valid, beat_ack, wdog_err (from arbiter).
// master: requester/port side, slave: arbiter side.
interface mem_port_arbiter_if;
    import arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] last;
    logic               port_ready;
    logic [NUM_REQ-1:0] grant;
    logic [SEL_W-1:0]   mux_sel;
    logic               port_valid;
    logic [NUM_REQ-1:0] beat_ack;
    logic               wdog_err;

    modport master (
        output req, last, port_ready,
        input  grant, mux_sel, port_valid, beat_ack, wdog_err
    );

    modport slave (
        input  req, last, port_ready,
        output grant, mux_sel, port_valid, beat_ack, wdog_err
    );

endinterface

// File: rtl/rr_pick3.sv
// Combinational round-robin pick among three requesters.
// Ports: req[2:0] request levels, ptr[1:0] last winner (search starts at
// ptr+1 mod 3), any = some request present, winner = chosen index.
module rr_pick3
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   winner
);

    // Winner index doubles as the mux select encoding.
    always_comb begin
        any    = |req;
        winner = SEL_REQ0;
        case (ptr)
            2'd0: begin
                if      (req[1]) winner = SEL_REQ1;
                else if (req[2]) winner = SEL_REQ2;
                else if (req[0]) winner = SEL_REQ0;
            end
            2'd1: begin
                if      (req[2]) winner = SEL_REQ2;
                else if (req[0]) winner = SEL_REQ0;
                else if (req[1]) winner = SEL_REQ1;
            end
            default: begin
                if      (req[0]) winner = SEL_REQ0;
                else if (req[1]) winner = SEL_REQ1;
                else if (req[2]) winner = SEL_REQ2;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between three requesters,
// with per-grant burst sequencing and a registered mux select.
// Ports: clk, arst_n (async active-low), bus (mem_port_arbiter_if.slave).
// Optional: define ARB_WDOG_EN to add a stall watchdog (WDOG_CYCLES) that
// forces release and pulses wdog_err; otherwise wdog_err is tied 0.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_BEATS   = 8,
    parameter int unsigned CNT_W       = 4
`ifdef ARB_WDOG_EN
    ,
    parameter int unsigned WDOG_CYCLES = 16
`endif
) (
    input  logic              clk,
    input  logic              arst_n,
    mem_port_arbiter_if.slave bus
);

    arb_state_e         state;
    logic [NUM_REQ-1:0] grant_q;
    logic [SEL_W-1:0]   mux_sel_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SEL_W-1:0]   ptr_q;

    logic               pick_any;
    logic [SEL_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic               req_g;
    logic               last_g;
    logic               valid;
    logic               beat;
    logic               cap_hit;
    logic               wdog_hit;

    rr_pick3 u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_idx)
    );

    // Granted requester's signals, selected by the one-hot grant register.
    assign pick_oh = NUM_REQ'(1) << pick_idx;
    assign req_g   = |(bus.req & grant_q);
    assign last_g  = |(bus.last & grant_q);
    assign valid   = (state == BUSY) & req_g;
    assign beat    = valid & bus.port_ready;
    assign cap_hit = (cnt_q + CNT_W'(1)) == CNT_W'(MAX_BEATS);

`ifdef ARB_WDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] stall_q;
    logic            wdog_err_q;

    assign wdog_hit = valid & ~bus.port_ready &
                      ((stall_q + WD_W'(1)) == WD_W'(WDOG_CYCLES));

    // Stall counter: held clear outside BUSY, cleared on every beat.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_q    <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_err_q <= wdog_hit;
            if (state != BUSY || beat) begin
                stall_q <= '0;
            end else if (valid && !bus.port_ready) begin
                stall_q <= stall_q + WD_W'(1);
            end
        end
    end

    assign bus.wdog_err = wdog_err_q;
`else
    assign wdog_hit     = 1'b0;
    assign bus.wdog_err = 1'b0;
`endif

    // Arbitration FSM; every exit from BUSY passes through one IDLE bubble.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            grant_q   <= '0;
            mux_sel_q <= SEL_REQ0;
            cnt_q     <= '0;
            ptr_q     <= SEL_REQ2;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state     <= BUSY;
                        grant_q   <= pick_oh;
                        mux_sel_q <= onehot_to_sel(pick_oh);
                        ptr_q     <= pick_idx;
                        cnt_q     <= '0;
                    end
                end
                BUSY: begin
                    if (!req_g || (beat && (last_g || cap_hit)) || wdog_hit) begin
                        state     <= IDLE;
                        grant_q   <= '0;
                        mux_sel_q <= SEL_REQ0;
                    end else if (beat) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant      = grant_q;
    assign bus.mux_sel    = mux_sel_q;
    assign bus.port_valid = valid;
    assign bus.beat_ack   = grant_q & {NUM_REQ{beat}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: stimulus pushes expected
// grant starts and beats into queues, a negedge monitor pops and compares.
module tb_mem_port_arbiter;

    logic clk;
    logic arst_n;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [2:0] ack;
        logic [1:0] sel;
    } beat_t;

    beat_t      beat_q[$];
    logic [2:0] gstart_q[$];
    logic [2:0] prev_grant;
    int         n_checks;
    int         n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] exp_sel(input logic [2:0] g);
        if (g == 3'b100) return 2'b10;
        if (g == 3'b010) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_beats(input logic [2:0] g, input int n);
        beat_t b;
        b.ack = g;
        b.sel = exp_sel(g);
        for (int i = 0; i < n; i++) beat_q.push_back(b);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst_n         = 1'b0;
        bus.req        = 3'b000;
        bus.last       = 3'b000;
        bus.port_ready = 1'b1;
        #3;
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_mux_sel", 32'(bus.mux_sel), 32'h0);
        check("rst_port_valid", 32'(bus.port_valid), 32'h0);
        check("rst_wdog_err", 32'(bus.wdog_err), 32'h0);
        @(negedge clk);
        arst_n = 1'b1;
        tick(1);
    endtask

    // Monitor: beats and grant starts are checked against the queues.
    always @(negedge clk) begin
        if (arst_n) begin
            if (bus.port_valid && bus.port_ready) begin
                if (beat_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat actual=%0h expected=none at %0t", bus.beat_ack, $time);
                end else begin
                    beat_t e;
                    e = beat_q.pop_front();
                    check("beat_ack", 32'(bus.beat_ack), 32'(e.ack));
                    check("beat_mux_sel", 32'(bus.mux_sel), 32'(e.sel));
                end
            end
            if (bus.grant != 3'b000 && prev_grant == 3'b000) begin
                if (gstart_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_grant actual=%0h expected=none at %0t", bus.grant, $time);
                end else begin
                    logic [2:0] g;
                    g = gstart_q.pop_front();
                    check("grant_start", 32'(bus.grant), 32'(g));
                    check("grant_mux_sel", 32'(bus.mux_sel), 32'(exp_sel(g)));
                end
            end else if (bus.grant != 3'b000) begin
                check("grant_no_b2b", 32'(bus.grant), 32'(prev_grant));
            end
        end
        prev_grant = bus.grant;
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        prev_grant = 3'b000;

        // Single requester, 3 beats, last on the third.
        do_reset();
        gstart_q.push_back(3'b010);
        push_beats(3'b010, 3);
        bus.req = 3'b010;
        tick(1);
        check("t1_grant_latency", 32'(bus.grant), 32'h2);
        check("t1_mux_sel", 32'(bus.mux_sel), 32'h1);
        tick(2);
        bus.last = 3'b010;
        tick(1);
        bus.req  = 3'b000;
        bus.last = 3'b000;
        check("t1_release", 32'(bus.grant), 32'h0);
`ifndef ARB_WDOG_EN
        check("t1_wdog_tied", 32'(bus.wdog_err), 32'h0);
`endif
        tick(2);

        // Contention: all request, single-beat bursts, order 0,1,2,0.
        do_reset();
        gstart_q.push_back(3'b001);
        gstart_q.push_back(3'b010);
        gstart_q.push_back(3'b100);
        gstart_q.push_back(3'b001);
        push_beats(3'b001, 1);
        push_beats(3'b010, 1);
        push_beats(3'b100, 1);
        push_beats(3'b001, 1);
        bus.req  = 3'b111;
        bus.last = 3'b111;
        tick(1);
        check("t2_first_grant", 32'(bus.grant), 32'h1);
        tick(1);
        check("t2_bubble", 32'(bus.grant), 32'h0);
        tick(6);
        bus.req  = 3'b000;
        bus.last = 3'b000;
        check("t2_end_idle", 32'(bus.grant), 32'h0);
        tick(2);

        // Fairness cap: requester 0 never signals last, 2 is waiting.
        do_reset();
        gstart_q.push_back(3'b001);
        push_beats(3'b001, 8);
        gstart_q.push_back(3'b100);
        push_beats(3'b100, 1);
        bus.req = 3'b101;
        tick(9);
        check("t3_cap_release", 32'(bus.grant), 32'h0);
        tick(1);
        check("t3_next_grant", 32'(bus.grant), 32'h4);
        bus.req  = 3'b100;
        bus.last = 3'b100;
        tick(1);
        bus.req  = 3'b000;
        bus.last = 3'b000;
        check("t3_end_idle", 32'(bus.grant), 32'h0);
        tick(2);

        // Abort: requester 1 drops after 2 beats.
        do_reset();
        gstart_q.push_back(3'b010);
        push_beats(3'b010, 2);
        bus.req = 3'b010;
        tick(3);
        bus.req = 3'b000;
        @(negedge clk);
        check("t4_abort_valid", 32'(bus.port_valid), 32'h0);
        check("t4_abort_grant_held", 32'(bus.grant), 32'h2);
        tick(1);
        check("t4_abort_idle", 32'(bus.grant), 32'h0);
        tick(1);

        // Async reset mid-burst clears grant without a clock edge.
        gstart_q.push_back(3'b010);
        push_beats(3'b010, 1);
        bus.req = 3'b010;
        tick(1);
        @(negedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        check("t4_async_grant", 32'(bus.grant), 32'h0);
        check("t4_async_mux_sel", 32'(bus.mux_sel), 32'h0);
        bus.req = 3'b000;
        @(negedge clk);
        arst_n = 1'b1;
        tick(2);

        // Backpressure: port_ready low for 5 cycles, grant held.
        do_reset();
        gstart_q.push_back(3'b001);
        push_beats(3'b001, 1);
        bus.port_ready = 1'b0;
        bus.req        = 3'b001;
        bus.last       = 3'b001;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_valid_held", 32'(bus.port_valid), 32'h1);
            check("t5_no_ack", 32'(bus.beat_ack), 32'h0);
            check("t5_grant_held", 32'(bus.grant), 32'h1);
        end
        tick(1);
        bus.port_ready = 1'b1;
        tick(1);
        bus.req  = 3'b000;
        bus.last = 3'b000;
        check("t5_release", 32'(bus.grant), 32'h0);
        tick(2);

`ifdef ARB_WDOG_EN
        // Watchdog: stuck port releases after 16 stall cycles.
        do_reset();
        gstart_q.push_back(3'b001);
        gstart_q.push_back(3'b010);
        push_beats(3'b010, 1);
        bus.port_ready = 1'b0;
        bus.req        = 3'b011;
        tick(16);
        check("t6_held_before_limit", 32'(bus.grant), 32'h1);
        tick(1);
        check("t6_wdog_release", 32'(bus.grant), 32'h0);
        check("t6_wdog_pulse", 32'(bus.wdog_err), 32'h1);
        tick(1);
        check("t6_wdog_one_cycle", 32'(bus.wdog_err), 32'h0);
        check("t6_next_grant", 32'(bus.grant), 32'h2);
        bus.port_ready = 1'b1;
        bus.req        = 3'b010;
        bus.last       = 3'b010;
        tick(1);
        bus.req  = 3'b000;
        bus.last = 3'b000;
        check("t6_end_idle", 32'(bus.grant), 32'h0);
        tick(2);
`endif

        check("beat_q_drained", 32'(beat_q.size()), 32'h0);
        check("grant_q_drained", 32'(gstart_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter sharing one memory/bus port between three requesters.
- Sequences per-requester bursts and drives the 2-bit select of the team's 3-input datapath mux on the shared address/write-data path.
- Encoding: 2'b00 = requester 0, 2'b01 = requester 1, 2'b10 = requester 2.
- Sits between the fetch, load/store and debug/DMA masters and the single memory port.

Parameters:
- MAX_BEATS, 8, beats per grant before forced release (fairness cap); minimum 1.
- CNT_W, 4, beat counter width; must satisfy 2^CNT_W > MAX_BEATS.
- WDOG_CYCLES, 16, stall limit in cycles; used only with ARB_WDOG_EN.

Ports:
- clk  input  1  clock, rising edge.
- arst_n  input  1  asynchronous active-low reset.
- req  input  3  per-requester request level; held until its burst ends.
- last  input  3  per-requester last-beat marker, qualified by req.
- port_ready  input  1  shared port accepts a beat this cycle.
- grant  output  3  registered one-hot grant; 3'b000 when idle.
- mux_sel  output  2  select for the shared-path mux, decoded from grant; 2'b00 when idle.
- port_valid  output  1  = busy & req[granted].
- beat_ack  output  3  = grant & {3{port_valid & port_ready}}.
- wdog_err  output  1  one-cycle pulse on watchdog release; tied 0 without ARB_WDOG_EN.

Behaviour:
- Reset (arst_n low, async): state IDLE, grant = 0, mux_sel = 2'b00, beat count = 0, rr pointer = 2 (so requester 0 wins first), wdog_err = 0. Reset mid-burst aborts silently.
- States: IDLE, BUSY.
- IDLE:
  - If any req, pick the first set bit starting at (ptr+1) mod 3 and wrapping.
  - At the next edge: grant/mux_sel registered, ptr = winner, count = 0, state → BUSY.
  - Latency: req rising at edge t gives grant visible after edge t+1.
- BUSY:
  - Beat completes when req[g] & port_ready; count increments on each completed beat.
- BUSY → IDLE at the next edge when any of these holds:
  - a beat completes with last[g] = 1;
  - a beat completes and count+1 == MAX_BEATS (forced release, no error);
  - req[g] drops (abort, no beat counted).
- BUSY exit always clears grant.
- No back-to-back grants: one IDLE bubble cycle between bursts guarantees at most one grant edge per cycle.
- A new arbitration always starts after ptr; the just-served requester has lowest priority next round.
- last on a non-granted requester is ignored.
- Simultaneous last and MAX_BEATS hit is a single release.
- MAX_BEATS = 1: every burst is one beat.
- mux_sel and grant are glitch-free registers, never combinationally derived from req.

Optional Feature:
- ARB_WDOG_EN defined:
  - Stall counter in BUSY resets on each completed beat and increments while port_valid & ~port_ready.
  - On reaching WDOG_CYCLES: force BUSY → IDLE, pulse wdog_err for one cycle.
  - Counter clears on reset and on every BUSY entry.
- Undefined: no stall counter; wdog_err constant 0; a stalled port holds the grant indefinitely.

Decomposition:
- Package arb_pkg: NUM_REQ = 3; state enum {IDLE, BUSY}; select constants SEL_REQ0 = 2'b00, SEL_REQ1 = 2'b01, SEL_REQ2 = 2'b10; one-hot-to-select function.
- Sub-module rr_pick3 (combinational): inputs req[2:0], ptr[1:0]; outputs any, winner index[1:0].
- Top holds the FSM, counters and registers.

Test Plan:
- Single requester: req = 3'b010, last asserted on beat 3, port_ready = 1.
  → grant = 3'b010 and mux_sel = 2'b01 one cycle after req; 3 beat_ack[1] pulses; grant = 0 the cycle after the last beat.
- Contention: all three req held with last = 1 every beat.
  → grants in order 0, 1, 2, 0 with one idle cycle between each; mux_sel sequence 00, 01, 10, 00.
- Fairness cap, MAX_BEATS = 8: req[0] never asserts last while req[2] is pending.
  → release after exactly 8 acks; next grant = 3'b100.
- Abort and reset: req[1] drops mid-burst after 2 beats.
  → IDLE next edge, grant = 0.
  - arst_n pulsed low mid-burst → grant and mux_sel go 0 immediately, without waiting for a clock.
- Backpressure: port_ready low for 5 cycles during a burst.
  → port_valid stays 1, no beat_ack, count unchanged, grant held.
- ARB_WDOG_EN, WDOG_CYCLES = 16: port_ready stuck low.
  → release after 16 stall cycles, wdog_err high exactly 1 cycle, next requester granted after the bubble.
